// File: rtl/execute_mem_s3_uncached_pkg.sv
// Purpose : shared types and constants for the uncached memory-pipe s3 stage.
// Latency : n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   state_t     FSM state encoding for the uncached access controller
//   WSTRB_WORD  byte strobe pattern for a full-word access
package execute_mem_s3_uncached_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,   // ready to accept an s2 op
      ST_REQ   = 3'd1,   // request presented, waiting for bus acceptance
      ST_RESP  = 3'd2,   // waiting for response of a live op
      ST_DONE  = 3'd3,   // one-cycle commit to the ROB
      ST_DRAIN = 3'd4    // waiting for response of a killed op, no commit
   } state_t;

   localparam logic [3:0] WSTRB_WORD = 4'b1111;

endpackage

// File: rtl/execute_mem_uncached_lane.sv
// Purpose : builds write strobes/data and extracts the load byte lane for one access.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   byte_op    in   byte access (else word)
//   addr_lo    in   physical address bits [1:0]
//   store_data in   store operand
//   rdata      in   bus read data
//   wstrb      out  byte strobes for the request
//   wdata      out  write data (byte replicated to all lanes for byte stores)
//   load_data  out  load result (zero-extended selected lane for byte loads)
module execute_mem_uncached_lane
   import execute_mem_s3_uncached_pkg::*;
(
   input  logic        byte_op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   always_comb begin
      wstrb     = WSTRB_WORD;
      wdata     = store_data;
      load_data = rdata;
      if (byte_op) begin
         wstrb     = 4'b0001 << addr_lo;
         // Replicate so the slave sees the byte on whichever lane the strobe selects.
         wdata     = {4{store_data[7:0]}};
         load_data = {24'd0, rdata[{addr_lo, 3'b000} +: 8]};
      end
   end

endmodule

// File: rtl/execute_mem_s3_uncached.sv
// Purpose : executes uncached loads/stores from s2 as single-beat bus accesses, commits to ROB.
// Latency : fire N -> bus req N+1 -> resp N+2 (zero-wait) -> commit N+3 -> ready again N+4.
// Backpressure: one op in flight; s2 held off via o_s2_ready while busy; request held until accepted.
//
// Ports:
//   clk/resetn                      clock, synchronous active-low reset
//   i_flush                         kills un-committed work
//   i_valid .. i_store_data         s2 register outputs (op, ids, addresses, store data)
//   o_s2_ready                      high only in IDLE; an eligible op is taken that cycle
//   o_bus_req_* / i_bus_req_ready   single-beat request channel (valid/ready)
//   i_bus_resp_* / o_bus_resp_ready response channel (read data or write ack, error)
//   o_cmt_*                         one-cycle completion report to the ROB writeback port
module execute_mem_s3_uncached
   import execute_mem_s3_uncached_pkg::*;
#(
   parameter int ROB_W = 4,
   parameter int FID_W = 8
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [ROB_W-1:0] i_dst_rob,
   input  logic [FID_W-1:0] i_fid,
   input  logic             i_s_byte,
   input  logic             i_s_store,
   input  logic             i_s_load,
   input  logic [31:0]      i_agu_v_addr,
   input  logic [31:0]      i_agu_p_addr,
   input  logic             i_agu_p_uncached,
   input  logic [31:0]      i_store_data,
   output logic             o_s2_ready,
   output logic             o_bus_req_valid,
   input  logic             i_bus_req_ready,
   output logic             o_bus_req_write,
   output logic [31:0]      o_bus_req_addr,
   output logic [31:0]      o_bus_req_wdata,
   output logic [3:0]       o_bus_req_wstrb,
   input  logic             i_bus_resp_valid,
   output logic             o_bus_resp_ready,
   input  logic [31:0]      i_bus_resp_rdata,
   input  logic             i_bus_resp_err,
   output logic             o_cmt_valid,
   output logic [ROB_W-1:0] o_cmt_dst_rob,
   output logic [FID_W-1:0] o_cmt_fid,
   output logic [31:0]      o_cmt_data,
   output logic             o_cmt_err,
   output logic [31:0]      o_cmt_v_addr
);

   state_t           state_q, state_d;
   logic [ROB_W-1:0] rob_q;
   logic [FID_W-1:0] fid_q;
   logic             byte_q;
   logic             store_q;
   logic [31:0]      v_addr_q;
   logic [31:0]      p_addr_q;
   logic [31:0]      sdata_q;
   logic [31:0]      data_q;
   logic             err_q;
   logic             fire;
   logic [31:0]      lane_load;

   assign o_s2_ready = (state_q == ST_IDLE);
   assign fire = i_valid & i_agu_p_uncached & (i_s_load | i_s_store) & o_s2_ready & ~i_flush;

   execute_mem_uncached_lane u_lane (
      .byte_op    (byte_q),
      .addr_lo    (p_addr_q[1:0]),
      .store_data (sdata_q),
      .rdata      (i_bus_resp_rdata),
      .wstrb      (o_bus_req_wstrb),
      .wdata      (o_bus_req_wdata),
      .load_data  (lane_load)
   );

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (fire) state_d = ST_REQ;
         ST_REQ: begin
            // A request accepted in the flush cycle still owes us a response.
            if (i_flush)              state_d = i_bus_req_ready ? ST_DRAIN : ST_IDLE;
            else if (i_bus_req_ready) state_d = ST_RESP;
         end
         ST_RESP: begin
            // If the response lands in the flush cycle it is already consumed; nothing to drain.
            if (i_flush)               state_d = i_bus_resp_valid ? ST_IDLE : ST_DRAIN;
            else if (i_bus_resp_valid) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_DRAIN: if (i_bus_resp_valid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rob_q    <= '0;
         fid_q    <= '0;
         byte_q   <= 1'b0;
         store_q  <= 1'b0;
         v_addr_q <= '0;
         p_addr_q <= '0;
         sdata_q  <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         if (fire) begin
            rob_q    <= i_dst_rob;
            fid_q    <= i_fid;
            byte_q   <= i_s_byte;
            store_q  <= i_s_store;
            v_addr_q <= i_agu_v_addr;
            p_addr_q <= i_agu_p_addr;
            sdata_q  <= i_store_data;
         end
         if ((state_q == ST_RESP) && i_bus_resp_valid) begin
            err_q  <= i_bus_resp_err;
            data_q <= (i_bus_resp_err || store_q) ? 32'd0 : lane_load;
         end
      end
   end

   assign o_bus_req_valid  = (state_q == ST_REQ);
   assign o_bus_req_write  = store_q;
   assign o_bus_req_addr   = {p_addr_q[31:2], 2'b00};
   assign o_bus_resp_ready = (state_q == ST_RESP) || (state_q == ST_DRAIN);

   assign o_cmt_valid   = (state_q == ST_DONE) & ~i_flush;
   assign o_cmt_dst_rob = rob_q;
   assign o_cmt_fid     = fid_q;
   assign o_cmt_data    = data_q;
   assign o_cmt_err     = err_q;
   assign o_cmt_v_addr  = v_addr_q;

   // Responses are only legal while one is owed.
   a_resp_expected: assert property (@(posedge clk) disable iff (!resetn)
      i_bus_resp_valid |-> ((state_q == ST_RESP) || (state_q == ST_DRAIN)));

endmodule
